// File: rtl/hsi_pkg.sv
// hsi_pkg: shared state, constants and FIFO entry type for the HSI capture controller
package hsi_pkg;
  localparam int HSI_WORD_W = 32;
  localparam int HSI_ARM_CYCLES = 2;
  typedef enum logic [2:0] {DISABLED, ARM, WAIT, CAPTURE, ABORT} hsi_state_t;
  typedef struct packed {
    logic [HSI_WORD_W-1:0] data;
    logic [3:0]            index;
    logic                  last;
  } hsi_entry_t;
endpackage

// File: rtl/hsi_word_fifo.sv
// hsi_word_fifo: synchronous word FIFO; a full FIFO still accepts a push when popping in the same cycle
module hsi_word_fifo
  import hsi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  hsi_entry_t wr_entry,
  input  logic       pop,
  output hsi_entry_t rd_entry,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(FIFO_DEPTH);
  hsi_entry_t mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_entry = mem[rd_ptr];
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= wr_entry;
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/hsi_capture_ctrl.sv
// hsi_capture_ctrl: sequences the HSI tokenizer reset and groups its words into frames behind a valid/ready FIFO
module hsi_capture_ctrl
  import hsi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_enable,
  input  logic [3:0]            cfg_frame_words,
  input  logic [TIMEOUT_W-1:0]  cfg_timeout,
  input  logic                  tok_valid,
  input  logic [HSI_WORD_W-1:0] tok_data,
  output logic                  tok_reset,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [HSI_WORD_W-1:0] m_data,
  output logic [3:0]            m_index,
  output logic                  m_last,
  input  logic                  sts_clear,
  output logic                  sts_overflow,
  output logic                  sts_timeout,
  output logic [15:0]           sts_frame_count,
  output logic                  busy
);
  hsi_state_t state, state_next;
  logic [1:0] phase;
  logic [3:0] idx, cur_idx, n_last;
  logic [TIMEOUT_W-1:0] idle_cnt;
  logic accept, is_last, phase_done, timeout_hit, fifo_full, fifo_empty, drop;
  hsi_entry_t push_entry, head;
  assign n_last = (cfg_frame_words == 4'd0) ? 4'd0 : cfg_frame_words - 4'd1;
  assign cur_idx = (state == WAIT) ? 4'd0 : idx;
  assign is_last = cur_idx == n_last;
  assign accept = tok_valid && cfg_enable && (state == WAIT || state == CAPTURE);
  assign phase_done = phase == 2'(HSI_ARM_CYCLES - 1);
  // a word arriving on the deadline cycle keeps the frame alive
  assign timeout_hit = state == CAPTURE && cfg_enable && !tok_valid && cfg_timeout != '0 && idle_cnt + 1'b1 == cfg_timeout;
  assign drop = accept && fifo_full && !m_ready;
  assign m_valid = !fifo_empty;
  assign push_entry = '{data: tok_data, index: cur_idx, last: is_last};
  assign m_data = head.data;
  assign m_index = head.index;
  assign m_last = head.last;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= DISABLED;
      phase <= '0;
    end else begin
      state <= state_next;
      phase <= (state_next != state) ? 2'd0 : phase + 2'd1;
    end
  end
  always_comb begin
    state_next = state;
    case (state)
      DISABLED: state_next = cfg_enable ? ARM : DISABLED;
      ARM:      state_next = !cfg_enable ? DISABLED : (phase_done ? WAIT : ARM);
      WAIT:     state_next = !cfg_enable ? DISABLED : ((tok_valid && n_last != 4'd0) ? CAPTURE : WAIT);
      CAPTURE:  state_next = !cfg_enable ? DISABLED : ((accept && is_last) ? WAIT : (timeout_hit ? ABORT : CAPTURE));
      ABORT:    state_next = !phase_done ? ABORT : (cfg_enable ? WAIT : DISABLED);
      default:  state_next = DISABLED;
    endcase
  end
  always_comb busy = state == CAPTURE || state == ABORT;
  always_ff @(posedge clock) begin
    if (reset) begin
      tok_reset <= 1'b1;
      idx <= '0;
      idle_cnt <= '0;
      sts_frame_count <= '0;
      sts_overflow <= 1'b0;
      sts_timeout <= 1'b0;
    end else begin
      tok_reset <= !(state == WAIT || state == CAPTURE);
      idx <= accept ? (is_last ? 4'd0 : cur_idx + 4'd1) : idx;
      idle_cnt <= (state == CAPTURE && !tok_valid) ? idle_cnt + 1'b1 : '0;
      sts_frame_count <= sts_frame_count + 16'(accept && is_last);
      sts_overflow <= drop || (sts_overflow && !sts_clear);
      sts_timeout <= timeout_hit || (sts_timeout && !sts_clear);
    end
  end
  hsi_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (accept),
    .wr_entry (push_entry),
    .pop      (m_ready),
    .rd_entry (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );
endmodule

// File: tb/tb_hsi_capture_ctrl.sv
// tb_hsi_capture_ctrl: directed and randomized checks of hsi_capture_ctrl against a frame-level model
module tb_hsi_capture_ctrl;
  localparam int DEPTH = 4;
  localparam int TW = 16;
  localparam int OFF = 0, ARMING = 1, READY = 2, INFRAME = 3, ABORTING = 4;
  logic clock = 1'b0, reset = 1'b1, cfg_enable = 1'b0, tok_valid = 1'b0, m_ready = 1'b0, sts_clear = 1'b0;
  logic [3:0] cfg_frame_words = 4'd0;
  logic [TW-1:0] cfg_timeout = '0;
  logic [31:0] tok_data = '0;
  logic tok_reset, m_valid, m_last, sts_overflow, sts_timeout, busy;
  logic [31:0] m_data;
  logic [3:0] m_index;
  logic [15:0] sts_frame_count;
  int vectors = 0, miscompares = 0;
  int mode = OFF, hold = 0, pos = 0, quiet = 0, frames = 0;
  bit movf = 1'b0, mto = 1'b0, mtokr = 1'b1;
  logic [36:0] q[$];

  always #5 clock = ~clock;

  hsi_capture_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_W(TW)) dut (
    .clock(clock), .reset(reset), .cfg_enable(cfg_enable), .cfg_frame_words(cfg_frame_words),
    .cfg_timeout(cfg_timeout), .tok_valid(tok_valid), .tok_data(tok_data), .tok_reset(tok_reset),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index), .m_last(m_last),
    .sts_clear(sts_clear), .sts_overflow(sts_overflow), .sts_timeout(sts_timeout),
    .sts_frame_count(sts_frame_count), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // frame-level reference: words per frame, quiet-clock budget, bounded queue
  task automatic model_step();
    int n;
    bit accept, popping, was_full, ovf_set, to_set;
    if (reset) begin
      mode = OFF; hold = 0; pos = 0; quiet = 0; frames = 0;
      movf = 1'b0; mto = 1'b0; mtokr = 1'b1;
      q.delete();
      return;
    end
    n = (cfg_frame_words == 4'd0) ? 1 : int'(cfg_frame_words);
    mtokr = !(mode == READY || mode == INFRAME);
    accept = cfg_enable && tok_valid && (mode == READY || mode == INFRAME);
    was_full = q.size() == DEPTH;
    popping = m_ready && q.size() != 0;
    if (popping) void'(q.pop_front());
    ovf_set = 1'b0;
    to_set = 1'b0;
    if (accept) begin
      if (was_full && !popping) ovf_set = 1'b1;
      else q.push_back({tok_data, 4'(pos), pos == n - 1});
      quiet = 0;
      if (pos == n - 1) begin
        frames++; pos = 0; mode = READY;
      end else begin
        pos++; mode = INFRAME;
      end
    end else begin
      case (mode)
        OFF: if (cfg_enable) begin mode = ARMING; hold = 0; end
        ARMING: begin
          hold++;
          if (!cfg_enable) mode = OFF;
          else if (hold == 2) mode = READY;
        end
        READY: if (!cfg_enable) mode = OFF;
        INFRAME: begin
          if (!cfg_enable) begin
            mode = OFF; pos = 0; quiet = 0;
          end else begin
            quiet++;
            if (cfg_timeout != 0 && quiet == int'(cfg_timeout)) begin
              to_set = 1'b1; mode = ABORTING; hold = 0; pos = 0; quiet = 0;
            end
          end
        end
        ABORTING: begin
          hold++;
          if (hold == 2) mode = cfg_enable ? READY : OFF;
        end
        default: mode = OFF;
      endcase
    end
    movf = ovf_set || (movf && !sts_clear);
    mto = to_set || (mto && !sts_clear);
  endtask

  task automatic check_all();
    chk("tok_reset", 64'(tok_reset), 64'(mtokr));
    chk("busy", 64'(busy), 64'(mode == INFRAME || mode == ABORTING));
    chk("m_valid", 64'(m_valid), 64'(q.size() != 0));
    if (q.size() != 0) chk("payload", 64'({m_data, m_index, m_last}), 64'(q[0]));
    chk("sts_overflow", 64'(sts_overflow), 64'(movf));
    chk("sts_timeout", 64'(sts_timeout), 64'(mto));
    chk("frame_count", 64'(sts_frame_count), 64'(frames & 16'hFFFF));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1 check_all();
  endtask

  task automatic send(input logic [31:0] d);
    tok_valid = 1'b1;
    tok_data = d;
    tick();
    tok_valid = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_index", 64'(m_index), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_tok_reset", 64'(tok_reset), 64'd1);
    reset = 1'b0;
    cfg_enable = 1'b1; cfg_frame_words = 4'd3; m_ready = 1'b1;
    repeat (3) tick();
    chk("arm_tok_reset_held", 64'(tok_reset), 64'd1);
    tick();
    chk("armed_tok_reset", 64'(tok_reset), 64'd0);
    send(32'hA1); send(32'hA2); send(32'hA3);
    repeat (2) tick();
    chk("first_frame_count", 64'(sts_frame_count), 64'd1);
    cfg_timeout = 16'd10;
    send(32'hB1);
    repeat (9) tick();
    chk("pre_timeout", 64'(sts_timeout), 64'd0);
    tick();
    chk("timeout_set", 64'(sts_timeout), 64'd1);
    repeat (3) tick();
    send(32'hC1);
    chk("index_after_abort", 64'(m_index), 64'd0);
    chk("count_after_abort", 64'(sts_frame_count), 64'd1);
    sts_clear = 1'b1; tick(); sts_clear = 1'b0;
    chk("timeout_cleared", 64'(sts_timeout), 64'd0);
    send(32'hC2); send(32'hC3);
    cfg_timeout = '0; cfg_frame_words = 4'd0; m_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(32'hD0 + 32'(i));
    chk("overflow_set", 64'(sts_overflow), 64'd1);
    sts_clear = 1'b1; send(32'hD6);
    chk("overflow_wins_clear", 64'(sts_overflow), 64'd1);
    tick(); sts_clear = 1'b0;
    chk("overflow_cleared", 64'(sts_overflow), 64'd0);
    chk("n1_frames", 64'(sts_frame_count), 64'd9);
    m_ready = 1'b1; repeat (4) tick();
    chk("drained", 64'(m_valid), 64'd0);
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'hE0 + 32'(i));
    m_ready = 1'b1; send(32'hE4);
    chk("pushpop_full_no_ovf", 64'(sts_overflow), 64'd0);
    repeat (3) tick();
    chk("new_word_last", 64'(m_data), 64'hE4);
    tick();
    cfg_frame_words = 4'd3; m_ready = 1'b0;
    send(32'hF1);
    cfg_enable = 1'b0; send(32'hF2);
    chk("disabled_busy", 64'(busy), 64'd0);
    tick();
    chk("disabled_tok_reset", 64'(tok_reset), 64'd1);
    chk("partial_data", 64'(m_data), 64'hF1);
    chk("partial_last", 64'(m_last), 64'd0);
    m_ready = 1'b1; tick();
    chk("partial_drained", 64'(m_valid), 64'd0);
    for (int b = 0; b < 12; b++) begin
      cfg_enable = 1'b0; tok_valid = 1'b0; sts_clear = 1'b0;
      repeat (4) tick();
      cfg_frame_words = 4'($urandom_range(0, 5));
      cfg_timeout = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(2, 8));
      for (int c = 0; c < 250; c++) begin
        cfg_enable = $urandom_range(0, 199) != 0;
        tok_valid = $urandom_range(0, 99) < 55;
        tok_data = $urandom();
        m_ready = $urandom_range(0, 99) < 65;
        sts_clear = $urandom_range(0, 99) < 4;
        reset = (b == 6 && c == 100);
        tick();
        reset = 1'b0;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hsi_capture_ctrl.md
# hsi_capture_ctrl

Capture controller that sequences the gyro HSI tokenizer and buffers its output. It holds the tokenizer in reset when idle or after errors, groups decoded 32-bit words into frames of a configured length, and detects stalled frames with an idle timeout. Completed words are queued in a small FIFO behind a valid/ready stream toward the AXI register/stream side. It sits between the tokenizer (`valid_out`/`data_out`) and the AXI slave logic of the axi_gyro_hsi IP.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: word FIFO entries; power of two, ≥2.
- `TIMEOUT_W`, 16: width of the idle-timeout counter and `cfg_timeout`.

Ports:
- `clock`  in  1  system clock; tokenizer FSM clock.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_enable`  in  1  capture enable.
- `cfg_frame_words`  in  4  words per frame; 0 is treated as 1.
- `cfg_timeout`  in  TIMEOUT_W  idle clocks allowed mid-frame; 0 disables the timeout.
- `tok_valid`  in  1  tokenizer word strobe, one clock wide.
- `tok_data`  in  32  tokenizer word.
- `tok_reset`  out  1  active-high tokenizer reset; top level drives tokenizer `reset_n = ~tok_reset`.
- `m_valid`  out  1  output word available.
- `m_ready`  in  1  consumer accepts word.
- `m_data`  out  32  word.
- `m_index`  out  4  word position in frame, 0-based.
- `m_last`  out  1  final word of frame.
- `sts_clear`  in  1  clears sticky status.
- `sts_overflow`  out  1  sticky: word dropped on full FIFO.
- `sts_timeout`  out  1  sticky: frame aborted by timeout.
- `sts_frame_count`  out  16  completed frames, wrapping.
- `busy`  out  1  high in CAPTURE or ABORT.

## Operation
- Reset values: state DISABLED, `tok_reset`=1, `m_valid`=0, FIFO empty, `m_data`/`m_index`/`m_last`=0, stickies 0, `sts_frame_count`=0, `busy`=0.
- Let N = max(`cfg_frame_words`,1).
- DISABLED: `tok_reset`=1. When `cfg_enable`=1, go to ARM.
- ARM: `tok_reset`=1 for exactly 2 clocks, then go to WAIT.
- WAIT: `tok_reset`=0, idle counter held at 0. On `tok_valid`, push {data, index 0, last=(N==1)}.
  - N==1: increment frame count and stay in WAIT.
  - Otherwise: set word index to 1 and go to CAPTURE.
- CAPTURE: `tok_reset`=0.
  - On `tok_valid`: push {data, idx, last=(idx==N-1)} and clear the idle counter. On the last word, increment frame count and go to WAIT; otherwise increment idx.
  - Without `tok_valid`: increment the idle counter. When the count equals a nonzero `cfg_timeout`, set `sts_timeout` and go to ABORT. `tok_valid` in that same cycle wins, and no timeout is taken.
- ABORT: `tok_reset`=1 for 2 clocks, then go to WAIT, or to DISABLED if `cfg_enable`=0. A partial frame is not completed; no `m_last` is emitted for it.
- `cfg_enable`=0 in ARM, WAIT or CAPTURE: go to DISABLED next clock. Queued words still drain; a `tok_valid` in that cycle is ignored. In ABORT, the 2-clock reset completes first.
- `tok_valid` in DISABLED, ARM or ABORT is ignored.
- Overflow: a push while the FIFO is full and not popping drops the word and sets `sts_overflow`. Index and frame accounting proceed as if the word had been accepted.
- Push and pop in the same cycle on a full FIFO: both succeed, no overflow.
- `sts_clear` clears both stickies. A set event in the same cycle wins.
- `sts_frame_count` wraps 0xFFFF→0.

## Timing
- `tok_valid` into an empty FIFO: `m_valid`=1 on the next clock, with data/index/last registered.
- Standard valid/ready: `m_valid` and payload stay stable until `m_ready`. A pop occurs on the `m_valid & m_ready` edge. Back-to-back pops at 1 word/clock.
- `tok_reset` is a registered output: it changes the clock after the state transition.
- Frame count updates the clock after the last word's `tok_valid`, independent of FIFO drain.
- Timeout: abort is taken on the clock where the idle count reaches `cfg_timeout`, i.e. `cfg_timeout` clocks after the last accepted word.
- `reset` asserted mid-frame: all state returns to reset values on the next edge, and FIFO contents are discarded.

## Structure
- Package `hsi_pkg`:
  - state enum {DISABLED, ARM, WAIT, CAPTURE, ABORT}
  - `HSI_WORD_W`=32
  - `HSI_ARM_CYCLES`=2
  - FIFO entry struct {data[31:0], index[3:0], last}
- Sub-module `hsi_word_fifo`: synchronous FIFO of 37-bit entries with depth `FIFO_DEPTH`, registered output, full/empty, and simultaneous push/pop on full.
- The controller FSM, idle counter, index counter and status logic live in `hsi_capture_ctrl`.

## Test plan
- Reset, then `cfg_enable`=1, N=3, `m_ready`=1, three `tok_valid` words 0xA1,0xA2,0xA3 → `tok_reset` high 2 clocks after ARM. Outputs: indices 0,1,2; `m_last` only on 0xA3; `sts_frame_count`=1.
- N=3, `cfg_timeout`=10, one word then silence → on the 10th idle clock `sts_timeout`=1, `tok_reset` pulses 2 clocks, back to WAIT. The next word has index 0; frame count unchanged.
- `m_ready`=0, FIFO_DEPTH=4, 6 words → 4 queued, `sts_overflow`=1. With `m_ready`=1, exactly 4 words drain in order.
- Full FIFO with `m_ready`=1 and `tok_valid` in the same cycle → no overflow, and the new word is the last drained.
- `sts_clear` coincident with an overflow event → `sts_overflow` remains 1. `sts_clear` alone → 0.
- `cfg_enable` dropped mid-frame after 1 of 3 words → DISABLED, `tok_reset`=1, the queued word still drains with `m_last`=0. `cfg_frame_words`=0 behaves as N=1: every word has `m_last`=1.
